// File: rtl/key_beep_drv.sv
// Turns one-cycle key_down events into key-index+1 buzzer bursts separated by silent gaps.
// Optional KEY_BEEP_QUEUE_EN builds a one-deep pending request that is played after the current pattern.
module key_beep_drv #(
  parameter int KEY_W     = 2,
  parameter int TONE_HALF = 25_000,
  parameter int BEEP_TIME = 5_000_000,
  parameter int GAP_TIME  = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_down,
  output logic             beep,
  output logic             busy
);

  localparam int DUR_MAX = (BEEP_TIME > GAP_TIME) ? BEEP_TIME : GAP_TIME;
  localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
  localparam int TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int BL_W    = $clog2(KEY_W + 1);

  localparam logic [DUR_W-1:0]  BEEP_LAST = DUR_W'(BEEP_TIME - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_TIME - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam logic [BL_W-1:0]   BL_ONE    = BL_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TONE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state;
  logic [DUR_W-1:0]  dur_cnt;
  logic [TONE_W-1:0] tone_cnt;
  logic [BL_W-1:0]   beeps_left;
  logic [BL_W-1:0]   key_cnt;
  logic              key_any;
  logic              last_end;
  logic              next_vld;
  logic [BL_W-1:0]   next_cnt;

  // Burst count for the lowest set key; scanning downward lets the lowest index win.
  always_comb begin
    key_cnt = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (key_down[i]) key_cnt = BL_W'(i + 1);
    end
  end

  assign key_any  = |key_down;
  assign last_end = (state == S_TONE) && (dur_cnt == BEEP_LAST) && (beeps_left == BL_ONE);

`ifdef KEY_BEEP_QUEUE_EN
  logic            pend_vld;
  logic [BL_W-1:0] pend_cnt;

  // A request arriving in the final burst cycle is newer than the stored one, so it wins.
  always_comb begin
    next_vld = pend_vld;
    next_cnt = pend_cnt;
    if (key_any) begin
      next_vld = 1'b1;
      next_cnt = key_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_cnt <= '0;
    end else if (busy) begin
      if (last_end) begin
        pend_vld <= 1'b0;
        pend_cnt <= '0;
      end else if (key_any) begin
        pend_vld <= 1'b1;
        pend_cnt <= key_cnt;
      end
    end
  end
`else
  assign next_vld = 1'b0;
  assign next_cnt = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      dur_cnt    <= '0;
      tone_cnt   <= '0;
      beeps_left <= '0;
      beep       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_any) begin
            state      <= S_TONE;
            beeps_left <= key_cnt;
            dur_cnt    <= '0;
            tone_cnt   <= '0;
            beep       <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_TONE: begin
          if (dur_cnt == BEEP_LAST) begin
            beep     <= 1'b0;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            if (!last_end) begin
              state      <= S_GAP;
              beeps_left <= beeps_left - 1'b1;
            end else if (next_vld) begin
              state      <= S_GAP;
              beeps_left <= next_cnt;
            end else begin
              state      <= S_IDLE;
              beeps_left <= '0;
              busy       <= 1'b0;
            end
          end else begin
            dur_cnt <= dur_cnt + 1'b1;
            if (tone_cnt == TONE_LAST) begin
              tone_cnt <= '0;
              beep     <= ~beep;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (dur_cnt == GAP_LAST) begin
            state    <= S_TONE;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            beep     <= 1'b1;
          end else begin
            dur_cnt <= dur_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          beep  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_beep_drv.sv
// Scoreboard bench for key_beep_drv: a plan-of-samples reference model feeds an expected queue.
module tb_key_beep_drv;

  localparam int KW = 2;
  localparam int TH = 2;
  localparam int BT = 8;
  localparam int GT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [KW-1:0] key_down = '0;
  logic          beep;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  key_beep_drv #(
    .KEY_W(KW), .TONE_HALF(TH), .BEEP_TIME(BT), .GAP_TIME(GT)
  ) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .beep(beep), .busy(busy)
  );

  always #5 clk = ~clk;

  // Future beep samples of the pattern being played; busy is simply "plan not empty".
  bit         plan[$];
  logic [1:0] sb[$];
  bit         pend_vld = 1'b0;
  int         pend_k   = 0;

  function automatic int lowest(input logic [KW-1:0] v);
    for (int i = 0; i < KW; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic add_pattern(input int k);
    for (int b = 0; b <= k; b++) begin
      if (b > 0) for (int g = 0; g < GT; g++) plan.push_back(1'b0);
      for (int i = 0; i < BT; i++) plan.push_back(((i / TH) % 2) == 0);
    end
  endtask

  initial forever begin
    bit busy_now;
    @(posedge clk);
    cyc++;
    if (rst) begin
      plan.delete();
      pend_vld = 1'b0;
      sb.push_back(2'b00);
    end else begin
      busy_now = (plan.size() > 0);
      if (busy_now) void'(plan.pop_front());
      if (!busy_now) begin
        if (key_down != '0) add_pattern(lowest(key_down));
      end else begin
`ifdef KEY_BEEP_QUEUE_EN
        if (key_down != '0) begin
          pend_vld = 1'b1;
          pend_k   = lowest(key_down);
        end
        if (plan.size() == 0 && pend_vld) begin
          for (int g = 0; g < GT; g++) plan.push_back(1'b0);
          add_pattern(pend_k);
          pend_vld = 1'b0;
        end
`endif
      end
      sb.push_back((plan.size() > 0) ? {plan[0], 1'b1} : 2'b00);
    end
  end

  initial forever begin
    logic [1:0] exp;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_underrun cycle %0d: no expected entry", cyc);
    end else begin
      exp = sb.pop_front();
      if ({beep, busy} !== exp) begin
        errors++;
        $display("FAIL beep_busy cycle %0d: actual beep=%b busy=%b required beep=%b busy=%b",
                 cyc, beep, busy, exp[1], exp[0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [KW-1:0] v);
    @(negedge clk); #1;
    key_down = v;
    @(negedge clk); #1;
    key_down = '0;
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (beep !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: actual beep=%b busy=%b required beep=0 busy=0", beep, busy);
    end
    repeat (hold) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    key_down = 2'b11;
    idle(3);
    #1;
    rst      = 1'b0;
    key_down = '0;
    idle(3);

    pulse(2'b01); idle(12);
    pulse(2'b10); idle(24);
    pulse(2'b11); idle(12);

    pulse(2'b01); idle(2);
    pulse(2'b10); idle(36);

    pulse(2'b01); idle(3);
    async_reset(2);
    idle(20);

    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk); #1;
      r        = $urandom_range(0, 99);
      key_down = (r < 15) ? KW'($urandom_range(1, 3)) : '0;
      rst      = (r == 99);
    end
    @(negedge clk); #1;
    key_down = '0;
    rst      = 1'b0;
    idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
